// File: rtl/uart_telemetry_tx.sv
// uart_telemetry_tx
// Measures frames per window from frame_done and, once per window, sends a
// 6-byte status packet to the host through the uart_transmitter
// wr/busy/dat handshake.
//
// Packet: SYNC, seq, fps[15:8], fps[7:0], status, xor checksum.
// status = {5'b0, dropped, sat, caster_ready}
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no packet in flight; a tick freezes a snapshot into pkt_buf
// LOAD  | current byte presented, waiting for transmitter not busy
// START | write strobe high for this single cycle
// ACK   | waiting for transmitter to raise busy
// DONE  | waiting for busy to drop; then next byte or back to IDLE
module uart_telemetry_tx #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_done,
    input  logic       caster_ready,
    input  logic       uart_tx_busy,
    output logic       uart_tx_start,
    output logic [7:0] uart_tx_byte,
    output logic       overrun
);

    localparam int unsigned      WIN_W    = $clog2(CLK_HZ);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(CLK_HZ - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_ACK,
        ST_DONE
    } state_t;

    state_t           state;
    logic [WIN_W-1:0] win_left;
    logic             tick;
    logic [15:0]      frame_ctr;
    logic             sat_flag;
    logic             frame_full;
    logic [15:0]      fps_now;
    logic             sat_now;
    logic [7:0]       seq;
    logic             dropped;
    logic [2:0]       idx;
    logic [47:0]      pkt_buf;
    logic [7:0]       snap_status;
    logic [7:0]       snap_chk;

    // The window timer counts down the cycles left in the window; the
    // cycle it reads zero is the window's last cycle (tick).
    assign tick = (win_left == '0);

    // Window timer: reload at terminal count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_left <= WIN_LAST;
        end else if (tick) begin
            win_left <= WIN_LAST;
        end else begin
            win_left <= win_left - 1'b1;
        end
    end

    assign frame_full = (frame_ctr == 16'hFFFF);

    // Snapshot values include a frame_done arriving in the tick cycle itself.
    // sat marks that at least one frame could not be counted this window.
    always_comb begin
        fps_now = frame_ctr;
        sat_now = sat_flag;
        if (frame_done) begin
            if (frame_full) begin
                sat_now = 1'b1;
            end else begin
                fps_now = frame_ctr + 16'd1;
            end
        end
    end

    // Per-window frame counter with saturation; restarts on every tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_ctr <= 16'd0;
            sat_flag  <= 1'b0;
        end else if (tick) begin
            frame_ctr <= 16'd0;
            sat_flag  <= 1'b0;
        end else begin
            frame_ctr <= fps_now;
            sat_flag  <= sat_now;
        end
    end

    // Status byte and checksum of the packet that would be frozen this cycle.
    always_comb begin
        snap_status = {5'b0, dropped, sat_now, caster_ready};
        snap_chk    = SYNC_BYTE ^ seq ^ fps_now[15:8] ^ fps_now[7:0] ^ snap_status;
    end

    // Packet sequencer. pkt_buf shifts left one byte per completed byte so
    // its top byte is always the one being sent. The dropped flag is cleared
    // when it is copied into a snapshot, so a drop that happens while that
    // very packet is in flight still reaches the following packet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            idx           <= 3'd0;
            seq           <= 8'd0;
            dropped       <= 1'b0;
            overrun       <= 1'b0;
            pkt_buf       <= 48'd0;
            uart_tx_start <= 1'b0;
            uart_tx_byte  <= 8'd0;
        end else begin
            uart_tx_start <= 1'b0;
            if (tick && (state != ST_IDLE)) begin
                dropped <= 1'b1;
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    uart_tx_byte <= 8'd0;
                    if (tick) begin
                        pkt_buf      <= {SYNC_BYTE, seq, fps_now, snap_status, snap_chk};
                        uart_tx_byte <= SYNC_BYTE;
                        idx          <= 3'd0;
                        dropped      <= 1'b0;
                        state        <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!uart_tx_busy) begin
                        uart_tx_start <= 1'b1;
                        state         <= ST_START;
                    end
                end
                ST_START: begin
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    if (uart_tx_busy) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!uart_tx_busy) begin
                        if (idx == 3'd5) begin
                            seq          <= seq + 8'd1;
                            uart_tx_byte <= 8'd0;
                            state        <= ST_IDLE;
                        end else begin
                            idx          <= idx + 3'd1;
                            pkt_buf      <= {pkt_buf[39:0], 8'd0};
                            uart_tx_byte <= pkt_buf[39:32];
                            state        <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
